// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush controller for the IF/ID and ID/EX buffers: load-use stalls,
// redirect flush windows and a full front-end freeze while data memory is busy.
module pipeline_hazard_ctrl #(
  parameter int REG_W        = 6,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic             ex_mem_read,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             redirect,
  input  logic             mem_busy,
  input  logic             stat_clr,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             id_ex_write,
  output logic             if_id_flush,
  output logic             id_ex_bubble,
  output logic [CNT_W-1:0] stall_count,
  output logic [1:0]       state_dbg
);

  typedef enum logic [1:0] {RUN = 2'b00, FLUSH = 2'b01, MEM_WAIT = 2'b10} state_e;

  localparam logic [2:0] RELOAD = (FLUSH_CYCLES > 1) ? 3'(FLUSH_CYCLES - 2) : 3'd0;

  state_e           state_q, state_d, saved_q, saved_d, eff_state;
  logic [2:0]       cnt_q, cnt_d, saved_cnt_q, saved_cnt_d, eff_cnt;
  logic [CNT_W-1:0] stall_count_q, stall_count_d;
  logic             hazard, pc_w, ifid_w, idex_w, flush, bubble;

  assign hazard = ex_mem_read && (ex_rd != '0) &&
                  ((id_use_rs && (id_rs == ex_rd)) || (id_use_rt && (id_rt == ex_rd)));

  always_comb begin
    // When memory releases, behave exactly as the state that was interrupted.
    eff_state = (state_q == MEM_WAIT) ? saved_q : state_q;
    if (eff_state != FLUSH) eff_state = RUN;
    eff_cnt = (state_q == MEM_WAIT) ? saved_cnt_q : cnt_q;

    pc_w        = 1'b1;
    ifid_w      = 1'b1;
    idex_w      = 1'b1;
    flush       = 1'b0;
    bubble      = 1'b0;
    state_d     = state_q;
    cnt_d       = cnt_q;
    saved_d     = saved_q;
    saved_cnt_d = saved_cnt_q;

    if (mem_busy) begin
      pc_w   = 1'b0;
      ifid_w = 1'b0;
      idex_w = 1'b0;
      if (state_q != MEM_WAIT) begin
        saved_d     = eff_state;
        saved_cnt_d = cnt_q;
        state_d     = MEM_WAIT;
      end
    end else begin
      state_d = eff_state;
      cnt_d   = eff_cnt;
      if (redirect || eff_state == FLUSH) begin
        flush  = 1'b1;
        bubble = 1'b1;
        if (redirect) begin
          state_d = (FLUSH_CYCLES > 1) ? FLUSH : RUN;
          cnt_d   = RELOAD;
        end else if (eff_cnt == 3'd0) begin
          state_d = RUN;
        end else begin
          cnt_d = eff_cnt - 3'd1;
        end
      end else if (hazard) begin
        pc_w   = 1'b0;
        ifid_w = 1'b0;
        bubble = 1'b1;
      end
    end

    stall_count_d = stall_count_q;
    if (stat_clr)
      stall_count_d = '0;
    else if ((!pc_w || flush) && !(&stall_count_q))
      stall_count_d = stall_count_q + {{(CNT_W-1){1'b0}}, 1'b1};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= RUN;
      cnt_q         <= 3'd0;
      saved_q       <= RUN;
      saved_cnt_q   <= 3'd0;
      stall_count_q <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      saved_q       <= saved_d;
      saved_cnt_q   <= saved_cnt_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign pc_write     = rst_n & pc_w;
  assign if_id_write  = rst_n & ifid_w;
  assign id_ex_write  = rst_n & idex_w;
  assign if_id_flush  = ~rst_n | flush;
  assign id_ex_bubble = ~rst_n | bubble;
  assign stall_count  = stall_count_q;
  assign state_dbg    = state_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: directed table, multi-cycle sequences, and
// random traffic against a remaining-flush-cycles model on FLUSH_CYCLES=2 and =1.
module tb_pipeline_hazard_ctrl;

  logic clk = 1'b0, rst_n = 1'b0;
  logic [5:0] id_rs, id_rt, ex_rd;
  logic id_use_rs, id_use_rt, ex_mem_read, redirect, mem_busy, stat_clr;
  logic pc_write, if_id_write, id_ex_write, if_id_flush, id_ex_bubble;
  logic pc_write1, if_id_write1, id_ex_write1, if_id_flush1, id_ex_bubble1;
  logic [15:0] stall_count, stall_count1;
  logic [1:0]  state_dbg, state_dbg1;
  int n_chk = 0, n_pass = 0;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.REG_W(6), .FLUSH_CYCLES(2), .CNT_W(16)) u_dut (
    .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs),
    .id_use_rt(id_use_rt), .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .redirect(redirect),
    .mem_busy(mem_busy), .stat_clr(stat_clr), .pc_write(pc_write), .if_id_write(if_id_write),
    .id_ex_write(id_ex_write), .if_id_flush(if_id_flush), .id_ex_bubble(id_ex_bubble),
    .stall_count(stall_count), .state_dbg(state_dbg));

  pipeline_hazard_ctrl #(.REG_W(6), .FLUSH_CYCLES(1), .CNT_W(16)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs),
    .id_use_rt(id_use_rt), .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .redirect(redirect),
    .mem_busy(mem_busy), .stat_clr(stat_clr), .pc_write(pc_write1), .if_id_write(if_id_write1),
    .id_ex_write(id_ex_write1), .if_id_flush(if_id_flush1), .id_ex_bubble(id_ex_bubble1),
    .stall_count(stall_count1), .state_dbg(state_dbg1));

  wire [4:0] out0 = {pc_write, if_id_write, id_ex_write, if_id_flush, id_ex_bubble};
  wire [4:0] out1 = {pc_write1, if_id_write1, id_ex_write1, if_id_flush1, id_ex_bubble1};

  typedef struct {
    logic       rd;
    logic [5:0] exrd, rs, rt;
    logic       urs, urt, redir, busy;
    logic [4:0] exp_out;
    logic [1:0] exp_st;
  } vec_t;

  localparam logic [4:0] NORM = 5'b11100, STALL = 5'b00101, FLSH = 5'b11111,
                         FRZ = 5'b00000, RSTO = 5'b00011;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic set_in(input logic rd, input logic [5:0] exrd, input logic [5:0] rs,
                        input logic [5:0] rt, input logic urs, input logic urt,
                        input logic redir, input logic busy, input logic clr);
    ex_mem_read = rd; ex_rd = exrd; id_rs = rs; id_rt = rt; id_use_rs = urs;
    id_use_rt = urt; redirect = redir; mem_busy = busy; stat_clr = clr;
  endtask

  task automatic idle();
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic cyc(input string nm, input logic [4:0] eo, input logic [1:0] es);
    @(negedge clk);
    chk({nm, ".out"}, 32'(out0), 32'(eo));
    chk({nm, ".st"}, 32'(state_dbg), 32'(es));
    @(posedge clk); #1;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Reference: owed flush cycles (including the current one) and a wait flag.
  int  m_fl[2], m_sc[2];
  bit  m_wait[2];
  int  m_fc[2] = '{2, 1};

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin m_fl[d] = 0; m_sc[d] = 0; m_wait[d] = 0; end
  endtask

  vec_t tbl[17];

  initial begin
    tbl[0]  = '{0, 0, 0, 0, 0, 0, 0, 0, NORM,  2'd0};
    tbl[1]  = '{1, 5, 5, 0, 1, 0, 0, 0, STALL, 2'd0};
    tbl[2]  = '{1, 0, 0, 0, 1, 0, 0, 0, NORM,  2'd0};
    tbl[3]  = '{1, 7, 1, 7, 0, 1, 0, 0, STALL, 2'd0};
    tbl[4]  = '{1, 5, 5, 0, 0, 0, 0, 0, NORM,  2'd0};
    tbl[5]  = '{0, 0, 0, 0, 0, 0, 1, 0, FLSH,  2'd0};
    tbl[6]  = '{0, 0, 0, 0, 0, 0, 0, 0, FLSH,  2'd1};
    tbl[7]  = '{0, 0, 0, 0, 0, 0, 0, 0, NORM,  2'd0};
    tbl[8]  = '{1, 5, 5, 0, 1, 0, 1, 0, FLSH,  2'd0};
    tbl[9]  = '{1, 5, 5, 0, 1, 0, 0, 0, FLSH,  2'd1};
    tbl[10] = '{0, 0, 0, 0, 0, 0, 1, 1, FRZ,   2'd0};
    tbl[11] = '{0, 0, 0, 0, 0, 0, 0, 0, NORM,  2'd2};
    tbl[12] = '{0, 0, 0, 0, 0, 0, 0, 0, NORM,  2'd0};
    tbl[13] = '{0, 0, 0, 0, 0, 0, 1, 0, FLSH,  2'd0};
    tbl[14] = '{0, 0, 0, 0, 0, 0, 1, 0, FLSH,  2'd1};
    tbl[15] = '{0, 0, 0, 0, 0, 0, 0, 0, FLSH,  2'd1};
    tbl[16] = '{0, 0, 0, 0, 0, 0, 0, 0, NORM,  2'd0};

    idle();
    repeat (2) @(posedge clk);
    #1;
    chk("rst.out", 32'(out0), 32'(RSTO));
    chk("rst.cnt", 32'(stall_count), 32'd0);
    chk("rst.st", 32'(state_dbg), 32'd0);
    rst_n = 1'b1;
    cyc("rel", NORM, 2'd0);

    for (int i = 0; i < 17; i++) begin
      set_in(tbl[i].rd, tbl[i].exrd, tbl[i].rs, tbl[i].rt, tbl[i].urs, tbl[i].urt,
             tbl[i].redir, tbl[i].busy, 1'b0);
      cyc($sformatf("tbl%0d", i), tbl[i].exp_out, tbl[i].exp_st);
    end

    // Redirect pulse: two flush cycles on FC=2, one on FC=1.
    idle(); stat_clr = 1; tick(); idle();
    redirect = 1;
    @(negedge clk); chk("fc1.out0", 32'(out1), 32'(FLSH));
    @(posedge clk); #1; idle();
    chk("fc1.st", 32'(state_dbg1), 32'd0);
    @(negedge clk); chk("fc1.out1", 32'(out1), 32'(NORM)); chk("fc2.out1", 32'(out0), 32'(FLSH));
    @(posedge clk); #1;
    cyc("fc2.done", NORM, 2'd0);
    chk("fc2.cnt", 32'(stall_count), 32'd2);
    chk("fc1.cnt", 32'(stall_count1), 32'd1);

    // Memory freeze in the middle of a flush window.
    stat_clr = 1; tick(); idle();
    redirect = 1; cyc("mw.redir", FLSH, 2'd0); idle();
    mem_busy = 1;
    cyc("mw.b0", FRZ, 2'd1);
    cyc("mw.b1", FRZ, 2'd2);
    cyc("mw.b2", FRZ, 2'd2);
    mem_busy = 0;
    cyc("mw.resume", FLSH, 2'd2);
    cyc("mw.run", NORM, 2'd0);
    chk("mw.cnt", 32'(stall_count), 32'd5);

    // Async reset asserted during a flush window.
    redirect = 1; tick(); idle();
    chk("rf.pre", 32'(state_dbg), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rf.out", 32'(out0), 32'(RSTO));
    chk("rf.cnt", 32'(stall_count), 32'd0);
    chk("rf.st", 32'(state_dbg), 32'd0);
    tick(); rst_n = 1'b1;
    cyc("rf.rel", NORM, 2'd0);

    // Random traffic against the model on both instances.
    rst_n = 1'b0; tick(); rst_n = 1'b1; model_reset();
    for (int k = 0; k < 400; k++) begin
      logic hz;
      logic [4:0] eo;
      set_in(1'($urandom_range(0, 1)), 6'($urandom_range(0, 3)), 6'($urandom_range(0, 3)),
             6'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             $urandom_range(0, 99) < 15, $urandom_range(0, 99) < 20, $urandom_range(0, 99) < 3);
      hz = ex_mem_read && ex_rd != 0 && ((id_use_rs && id_rs == ex_rd) || (id_use_rt && id_rt == ex_rd));
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        if (mem_busy) eo = FRZ;
        else if (redirect || m_fl[d] > 0) eo = FLSH;
        else if (hz) eo = STALL;
        else eo = NORM;
        chk($sformatf("rnd%0d.d%0d.out", k, d), 32'(d == 0 ? out0 : out1), 32'(eo));
        chk($sformatf("rnd%0d.d%0d.st", k, d), 32'(d == 0 ? state_dbg : state_dbg1),
            m_wait[d] ? 32'd2 : (m_fl[d] > 0 ? 32'd1 : 32'd0));
        chk($sformatf("rnd%0d.d%0d.cnt", k, d), 32'(d == 0 ? stall_count : stall_count1),
            32'(m_sc[d]));
        if (stat_clr) m_sc[d] = 0;
        else if ((!eo[4] || eo[1]) && m_sc[d] < 16'hFFFF) m_sc[d]++;
        if (mem_busy) m_wait[d] = 1;
        else begin
          m_wait[d] = 0;
          if (redirect) m_fl[d] = m_fc[d] - 1;
          else if (m_fl[d] > 0) m_fl[d]--;
        end
      end
      @(posedge clk); #1;
    end

    // Counter saturation and clear priority.
    idle(); stat_clr = 1; tick(); idle();
    mem_busy = 1;
    repeat (65534) tick();
    chk("sat.fffe", 32'(stall_count), 32'hFFFE);
    repeat (3) tick();
    chk("sat.ffff", 32'(stall_count), 32'hFFFF);
    stat_clr = 1; tick();
    chk("sat.clr", 32'(stall_count), 32'd0);
    idle();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
